// File: rtl/pcpi_mul_pkg.sv
// pcpi_mul_arbiter shared types and helpers.
// MUL-class decode used by the arbiter and its picker.
package pcpi_mul_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    RESP,
    DRAIN
  } state_e;

  localparam logic [6:0] OPC_OP    = 7'b0110011;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  // funct3 000..011 are MUL/MULH/MULHSU/MULHU; 1xx are DIV/REM
  function automatic logic is_mul(input logic [31:0] insn);
    return (insn[6:0] == OPC_OP) &&
           (insn[31:25] == F7_MULDIV) &&
           !insn[14];
  endfunction

  function automatic int cnt_w(input int timeout);
    return $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/pcpi_rr_pick.sv
// Round-robin picker: first set bit at or after ptr_i,
// wrapping modulo NUM_REQ.
module pcpi_rr_pick #(
  parameter  int NUM_REQ = 2,
  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] vec_i,
  input  logic [IW-1:0]      ptr_i,
  output logic [IW-1:0]      idx_o,
  output logic               any_o
);

  logic [IW:0] j;

  always_comb begin
    idx_o = '0;
    any_o = 1'b0;
    j     = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      j = {1'b0, ptr_i} + (IW+1)'(k);
      if (j >= (IW+1)'(NUM_REQ)) begin
        j = j - (IW+1)'(NUM_REQ);
      end
      if (!any_o && vec_i[j[IW-1:0]]) begin
        any_o = 1'b1;
        idx_o = j[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/pcpi_mul_arbiter.sv
// Shares one PCPI fast multiplier between NUM_REQ requesters,
// round-robin, one operation in flight, with abort and timeout.
import pcpi_mul_pkg::*;

module pcpi_mul_arbiter #(
  parameter int NUM_REQ     = 2,
  parameter int MUL_LATENCY = 2,
  parameter int TIMEOUT     = 15
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [NUM_REQ-1:0]    req_valid,
  input  logic [32*NUM_REQ-1:0] req_insn,
  input  logic [32*NUM_REQ-1:0] req_rs1,
  input  logic [32*NUM_REQ-1:0] req_rs2,
  output logic [NUM_REQ-1:0]    req_wait,
  output logic [NUM_REQ-1:0]    req_ready,
  output logic [NUM_REQ-1:0]    req_wr,
  output logic [31:0]           req_rd,
  output logic                  mul_valid,
  output logic [31:0]           mul_insn,
  output logic [31:0]           mul_rs1,
  output logic [31:0]           mul_rs2,
  input  logic                  mul_ready,
  input  logic                  mul_wr,
  input  logic [31:0]           mul_rd,
  output logic                  busy,
  output logic                  err_timeout
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = cnt_w(TIMEOUT);

  if (TIMEOUT <= MUL_LATENCY) begin : g_bad_timeout
    $error("TIMEOUT must exceed MUL_LATENCY");
  end
  if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num
    $error("NUM_REQ must be in 2..8");
  end

  state_e        state_q, state_d;
  logic [IW-1:0] gnt_q, gnt_d;
  logic [IW-1:0] ptr_q, ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   res_rd_q, res_rd_d;
  logic          res_wr_q, res_wr_d;
  logic          err_q, err_d;

  logic [NUM_REQ-1:0] elig;
  logic [IW-1:0]      pk_idx;
  logic               pk_any;
  logic               g_valid;
  logic [31:0]        g_insn, g_rs1, g_rs2;

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      elig[i] = req_valid[i] &&
                is_mul(req_insn[32*i +: 32]);
    end
  end

  pcpi_rr_pick #(
    .NUM_REQ (NUM_REQ)
  ) u_pick (
    .vec_i (elig),
    .ptr_i (ptr_q),
    .idx_o (pk_idx),
    .any_o (pk_any)
  );

  always_comb begin
    g_valid = 1'b0;
    g_insn  = '0;
    g_rs1   = '0;
    g_rs2   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt_q == IW'(i)) begin
        g_valid = req_valid[i];
        g_insn  = req_insn[32*i +: 32];
        g_rs1   = req_rs1[32*i +: 32];
        g_rs2   = req_rs2[32*i +: 32];
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    ptr_d    = ptr_q;
    cnt_d    = cnt_q;
    res_rd_d = res_rd_q;
    res_wr_d = res_wr_q;
    err_d    = err_q;
    unique case (state_q)
      IDLE: begin
        if (pk_any) begin
          gnt_d   = pk_idx;
          cnt_d   = '0;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        cnt_d = cnt_q + 1'b1;
        if (!g_valid) begin
          cnt_d   = '0;
          state_d = DRAIN;
        end else if (mul_ready) begin
          res_rd_d = mul_rd;
          res_wr_d = mul_wr;
          state_d  = RESP;
        end else if (cnt_q == CW'(TIMEOUT)) begin
          res_rd_d = '0;
          res_wr_d = 1'b0;
          err_d    = 1'b1;
          state_d  = RESP;
        end
      end
      RESP: begin
        ptr_d   = (gnt_q == IW'(NUM_REQ-1)) ?
                  '0 : gnt_q + 1'b1;
        state_d = IDLE;
      end
      DRAIN: begin
        // aborted op still completes inside the multiplier
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(MUL_LATENCY-1)) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= IDLE;
      gnt_q    <= '0;
      ptr_q    <= '0;
      cnt_q    <= '0;
      res_rd_q <= '0;
      res_wr_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      ptr_q    <= ptr_d;
      cnt_q    <= cnt_d;
      res_rd_q <= res_rd_d;
      res_wr_q <= res_wr_d;
      err_q    <= err_d;
    end
  end

  assign busy        = (state_q != IDLE);
  assign mul_valid   = (state_q == ISSUE);
  assign mul_insn    = mul_valid ? g_insn : '0;
  assign mul_rs1     = mul_valid ? g_rs1 : '0;
  assign mul_rs2     = mul_valid ? g_rs2 : '0;
  assign req_rd      = (state_q == RESP) ? res_rd_q : '0;
  assign err_timeout = err_q;
  // wait follows inputs, so force it low while held in reset
  assign req_wait    = resetn ? elig : '0;

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      req_ready[i] = (state_q == RESP) &&
                     (gnt_q == IW'(i));
      req_wr[i]    = req_ready[i] && res_wr_q;
    end
  end

endmodule

// File: doc/pcpi_mul_arbiter.md
# pcpi_mul_arbiter

Shares one `picorv32_pcpi_fast_mul` instance between NUM_REQ PCPI requesters, such as harts or pipelines. Eligible MUL-class requests are granted round-robin and issued one at a time. The block captures the multiplier result and returns it to the granted requester with a one-cycle ready/wr pulse. It also handles requester abort and multiplier timeout; a timeout sets a sticky error flag.

## Interface
- NUM_REQ, 2, number of requester ports (2..8)
- MUL_LATENCY, 2, cycles from multiplier valid to multiplier ready; 2 for EXTRA_MUL_FFS=0, 4 for EXTRA_MUL_FFS=1
- TIMEOUT, 15, maximum cycles in ISSUE before abandoning; must be > MUL_LATENCY
- clk  in  1  clock
- resetn  in  1  asynchronous, active-low reset
- req_valid  in  NUM_REQ  per-requester pcpi_valid
- req_insn  in  32*NUM_REQ  per-requester instruction; requester i occupies slice [32i+31:32i]
- req_rs1, req_rs2  in  32*NUM_REQ  per-requester operands
- req_wait  out  NUM_REQ  per-requester pcpi_wait
- req_ready  out  NUM_REQ  per-requester pcpi_ready; one-hot or zero
- req_wr  out  NUM_REQ  per-requester pcpi_wr
- req_rd  out  32  shared result bus; valid only where req_ready is set
- mul_valid  out  1  to multiplier pcpi_valid
- mul_insn, mul_rs1, mul_rs2  out  32 each  to multiplier
- mul_ready, mul_wr  in  1 each  from multiplier
- mul_rd  in  32  from multiplier
- busy  out  1  state != IDLE
- err_timeout  out  1  sticky; cleared only by reset

## Operation
- MUL-class instruction: insn[6:0]=0110011, insn[31:25]=0000001, insn[14:12] in {000,001,010,011}.
- eligible[i] = req_valid[i] && MUL-class(req_insn[i]).
- Requesters with non-MUL instructions are ignored: wait, ready and wr stay 0.
- req_wait[i] = eligible[i], asserted combinationally, including while the request is being serviced.
- State: IDLE, ISSUE, RESP, DRAIN. Registers: gnt (index), ptr (round-robin pointer), cnt, res_rd, res_wr.
- IDLE
  - If any eligible requester exists: gnt <= first eligible index at or after ptr, wrapping modulo NUM_REQ; cnt <= 0; go to ISSUE.
- ISSUE
  - mul_valid=1; mul_insn/rs1/rs2 = the slice of requester gnt, muxed combinationally.
  - cnt increments each cycle.
  - Priority within ISSUE, highest first: (1) abort, (2) mul_ready, (3) timeout.
  - Abort, when req_valid[gnt]=0: go to DRAIN with cnt <= 0.
  - mul_ready=1: res_rd <= mul_rd; res_wr <= mul_wr; go to RESP.
  - Timeout, when cnt == TIMEOUT: res_wr <= 0; res_rd <= 0; err_timeout <= 1; go to RESP.
- RESP
  - mul_valid=0; req_ready[gnt]=1; req_wr[gnt]=res_wr; req_rd=res_rd.
  - ptr <= (gnt+1) mod NUM_REQ; go to IDLE.
- DRAIN
  - mul_valid=0; mul_ready is ignored and the result discarded.
  - After MUL_LATENCY cycles, go to IDLE. ptr is unchanged, so the aborted requester keeps its priority.
- mul_valid is low for at least one cycle between operations, so the multiplier never re-issues a held request.

## Timing
- Reset (async, resetn=0) values:
  - state IDLE; ptr=0, gnt=0, cnt=0; res_rd=0, res_wr=0; err_timeout=0.
  - All outputs 0; req_rd=0.
- Reset asserted mid-ISSUE drops mul_valid immediately. The multiplier shares resetn, so no stale response can arrive.
- Latency from the first cycle req_valid is seen in IDLE to req_ready = MUL_LATENCY+2 cycles (4 with the default).
  - t0: IDLE grants.
  - t0+1: ISSUE begins.
  - t0+3: mul_ready seen.
  - t0+4: RESP.
- Requesters hold valid/insn/operands stable until req_ready and drop valid in the following cycle. Holding valid past that cycle starts a new operation.
- Throughput: one operation per MUL_LATENCY+3 cycles (IDLE, ISSUE, RESP).
- Simultaneous eligibility: the pointer decides.
  - After reset, requester 0 wins.
  - After serving k, the first eligible index from k+1 wins.
- A request that becomes valid in the same cycle as another requester's RESP is arbitrated in the next IDLE cycle.

## Structure
- Package pcpi_mul_pkg:
  - state enum (IDLE/ISSUE/RESP/DRAIN)
  - constants OPC_OP=7'b0110011, F7_MULDIV=7'b0000001
  - function is_mul(insn)
  - cnt width = $clog2(TIMEOUT+1)
- Sub-module pcpi_rr_pick (NUM_REQ): combinational first-set-at-or-after-pointer picker; outputs index and any.
- Elaboration-time assertion: TIMEOUT > MUL_LATENCY.

## Test plan
- Single MUL: requester 0 sends MUL rs1=7, rs2=6 against a real multiplier. Expect req_ready[0] and req_wr[0] on cycle 4, req_rd=42, mul_valid high exactly 3 cycles.
- MULHU: rs1=rs2=0xFFFFFFFF. Expect req_rd=0xFFFFFFFE. Also MULH rs1=0x80000000, rs2=2, expect req_rd=0xFFFFFFFF.
- Contention: both requesters valid from reset, each re-requesting immediately after ready. Expect grant order 0,1,0,1; each receives its own product; req_ready never both set.
- Abort: requester 1 drops valid in the second ISSUE cycle.
  - Expect DRAIN for MUL_LATENCY cycles, no req_ready, no response leakage.
  - Requester 1 re-requesting next is granted before requester 0.
- Timeout: stub multiplier never asserts mul_ready.
  - Expect RESP after TIMEOUT+1 ISSUE cycles with req_wr=0, req_rd=0, err_timeout=1.
  - err_timeout stays set until resetn is pulsed.
- Non-MUL and reset: an ADD insn (funct7=0) leaves wait/ready at 0 and the block stays IDLE. Asserting resetn=0 mid-ISSUE zeroes all outputs asynchronously.
